fp_apu_arbiter: RTL and testbench

Round-robin arbiter that shares one `fp_wrapper` FPU instance between `NUM_REQ` APU-protocol requesters (e.g. scalar core and vector issue stage). It forwards the winning request to the FPU, records its owner in an in-order tag FIFO, and routes each FPU response back to the requester that issued it. It sits between the requesters' APU master ports and the FPU's APU slave port.

---
 rtl/fp_arb_pkg.sv | 25 ++
 rtl/fp_tag_fifo.sv | 52 +++++
 rtl/fp_apu_arbiter.sv | 156 +++++++++++++++
 tb/tb_fp_apu_arbiter.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared APU protocol widths and payload records for the FPU arbiter.
package fp_arb_pkg;

    localparam int APU_NARGS    = 3;
    localparam int APU_WOP      = 6;
    localparam int APU_NDSFLAGS = 11;
    localparam int APU_NUSFLAGS = 5;

    typedef struct packed {
        logic [APU_NARGS-1:0][31:0] operands;
        logic [APU_WOP-1:0]         op;
        logic [APU_NDSFLAGS-1:0]    flags;
    } apu_req_t;

    typedef struct packed {
        logic [31:0]             rdata;
        logic [APU_NUSFLAGS-1:0] rflags;
    } apu_rsp_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_tag_fifo.sv
// In-order owner-tag FIFO; the arbiter never pushes while full or pops while empty.
module fp_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [TAG_W-1:0]         i_tag,
    output logic [TAG_W-1:0]         o_tag,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_tag;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_tag   = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fp_apu_arbiter.sv
// Round-robin arbiter sharing one FPU between APU requesters, routing
// in-order responses back to their issuers via a tag FIFO.
module fp_apu_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NUM_REQ-1:0]                          req_i,
    output logic [NUM_REQ-1:0]                          gnt_o,
    input  logic [NUM_REQ-1:0][APU_NARGS-1:0][31:0]     operands_i,
    input  logic [NUM_REQ-1:0][APU_WOP-1:0]             op_i,
    input  logic [NUM_REQ-1:0][APU_NDSFLAGS-1:0]        flags_i,
    output logic [NUM_REQ-1:0]                          rvalid_o,
    output logic [NUM_REQ-1:0][31:0]                    rdata_o,
    output logic [NUM_REQ-1:0][APU_NUSFLAGS-1:0]        rflags_o,
    output logic                                        fpu_req_o,
    input  logic                                        fpu_gnt_i,
    output logic [APU_NARGS-1:0][31:0]                  fpu_operands_o,
    output logic [APU_WOP-1:0]                          fpu_op_o,
    output logic [APU_NDSFLAGS-1:0]                     fpu_flags_o,
    input  logic                                        fpu_rvalid_i,
    input  logic [31:0]                                 fpu_rdata_i,
    input  logic [APU_NUSFLAGS-1:0]                     fpu_rflags_i,
    output logic                                        busy_o,
    output logic                                        err_o
);

    localparam int TAG_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [TAG_W:0]   NREQ_W = (TAG_W+1)'(NUM_REQ);
    localparam logic [TAG_W-1:0] LAST   = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0]                    r_rr_ptr;
    logic                                r_err;
    logic [NUM_REQ-1:0]                  r_rvalid;
    logic [NUM_REQ-1:0][31:0]            r_rdata;
    logic [NUM_REQ-1:0][APU_NUSFLAGS-1:0] r_rflags;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [TAG_W-1:0]     w_offset;
    logic [TAG_W:0]       w_sum;
    logic [TAG_W-1:0]     w_winner;
    logic [TAG_W-1:0]     w_next;
    logic                 w_any;
    apu_req_t             w_win_req;

    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [TAG_W-1:0] w_head;
    logic             w_hs;
    logic             w_bypass;
    logic             w_orphan;
    logic             w_push;
    logic             w_pop;
    logic [TAG_W-1:0] w_owner;

    // Rotate requests so the pointer sits at bit 0; the lowest set bit wins.
    assign w_req_dbl = {req_i, req_i};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr_ptr);
    assign w_any     = |req_i;

    always_comb begin
        w_offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_offset = TAG_W'(i);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_winner = (w_sum >= NREQ_W) ? (w_sum[TAG_W-1:0] - NREQ_W[TAG_W-1:0])
                                        : w_sum[TAG_W-1:0];
    assign w_next   = (w_winner == LAST) ? '0 : (w_winner + 1'b1);

    always_comb begin
        w_win_req = '0;
        if (w_any) begin
            w_win_req.operands = operands_i[w_winner];
            w_win_req.op       = op_i[w_winner];
            w_win_req.flags    = flags_i[w_winner];
        end
    end

    assign fpu_operands_o = w_win_req.operands;
    assign fpu_op_o       = w_win_req.op;
    assign fpu_flags_o    = w_win_req.flags;

    // A full FIFO blocks issue even when a pop frees a slot this cycle.
    assign fpu_req_o = w_any & ~w_full & ~rst_ni;
    assign w_hs      = fpu_req_o & fpu_gnt_i;

    always_comb begin
        gnt_o = '0;
        if (w_hs) begin
            gnt_o[w_winner] = 1'b1;
        end
    end

    // Latency-0 FPU: the response belongs to the op issued in the same cycle.
    assign w_bypass = fpu_rvalid_i & w_empty & w_hs;
    assign w_orphan = fpu_rvalid_i & w_empty & ~w_hs;
    assign w_pop    = fpu_rvalid_i & ~w_empty;
    assign w_push   = w_hs & ~w_bypass;
    assign w_owner  = w_empty ? w_winner : w_head;

    fp_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_tag   (w_winner),
        .o_tag   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_rflags <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_hs) begin
                r_rr_ptr <= w_next;
            end
            if (w_orphan) begin
                r_err <= 1'b1;
            end
            if (fpu_rvalid_i && !w_orphan) begin
                r_rvalid[w_owner] <= 1'b1;
                r_rdata[w_owner]  <= fpu_rdata_i;
                r_rflags[w_owner] <= fpu_rflags_i;
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign rflags_o = r_rflags;
    assign busy_o   = (w_count != '0);
    assign err_o    = r_err;

endmodule

// File: tb/tb_fp_apu_arbiter.sv
// Bench for fp_apu_arbiter: requester stimulus, fixed-latency FPU stub,
// reference arbitration model and an in-order response scoreboard.
module tb_fp_apu_arbiter;

    localparam int NREQ  = 2;
    localparam int DEPTH = 4;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic [4:0]  flags;
    } sb_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [1:0]            req = '0;
    logic [1:0][2:0][31:0] ops = '0;
    logic [1:0][5:0]       opc = '0;
    logic [1:0][10:0]      flg = '0;
    logic                  fpu_gnt = 1'b0;
    logic                  orphan = 1'b0;
    int                    lat = 0;

    logic [1:0]            gnt_o;
    logic [1:0]            rvalid_o;
    logic [1:0][31:0]      rdata_o;
    logic [1:0][4:0]       rflags_o;
    logic                  fpu_req_o;
    logic [2:0][31:0]      fpu_operands_o;
    logic [5:0]            fpu_op_o;
    logic [10:0]           fpu_flags_o;
    logic                  fpu_rvalid;
    logic [31:0]           fpu_rdata;
    logic [4:0]            fpu_rflags;
    logic                  busy_o;
    logic                  err_o;

    int  n_checks = 0;
    int  n_errors = 0;
    sb_t q[$];
    int  m_ptr = 0;
    int  m_count = 0;
    bit  m_err = 1'b0;

    logic        pv [8];
    logic [31:0] pd [8];
    logic [4:0]  pf [8];

    always #5 clk = ~clk;

    fp_apu_arbiter #(.NUM_REQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst),
        .req_i          (req),
        .gnt_o          (gnt_o),
        .operands_i     (ops),
        .op_i           (opc),
        .flags_i        (flg),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .rflags_o       (rflags_o),
        .fpu_req_o      (fpu_req_o),
        .fpu_gnt_i      (fpu_gnt),
        .fpu_operands_o (fpu_operands_o),
        .fpu_op_o       (fpu_op_o),
        .fpu_flags_o    (fpu_flags_o),
        .fpu_rvalid_i   (fpu_rvalid),
        .fpu_rdata_i    (fpu_rdata),
        .fpu_rflags_i   (fpu_rflags),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    // FPU stub: result = operand b, flags = op[4:0], fixed latency, in order.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= fpu_req_o & fpu_gnt;
            pd[0] <= fpu_operands_o[1];
            pf[0] <= fpu_op_o[4:0];
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
                pf[i] <= pf[i-1];
            end
        end
    end

    always_comb begin
        fpu_rvalid = 1'b0;
        fpu_rdata  = '0;
        fpu_rflags = '0;
        if (lat == 0) begin
            fpu_rvalid = fpu_req_o & fpu_gnt;
            fpu_rdata  = fpu_operands_o[1];
            fpu_rflags = fpu_op_o[4:0];
        end else begin
            fpu_rvalid = pv[lat-1];
            fpu_rdata  = pd[lat-1];
            fpu_rflags = pf[lat-1];
        end
        if (orphan) begin
            fpu_rvalid = 1'b1;
            fpu_rdata  = 32'hDEADBEEF;
            fpu_rflags = 5'h1F;
        end
    end

    function automatic void exp_win(input int ptr, input logic [1:0] r,
                                    output int w, output bit any);
        any = 1'b0;
        w   = ptr;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (ptr + i) % NREQ;
            if (!any && r[j]) begin
                any = 1'b1;
                w   = j;
            end
        end
    endfunction

    // Reference model: round-robin pointer, occupancy and orphan flag.
    always @(posedge clk) begin : model
        int w;
        bit any;
        bit hs;
        bit rv;
        exp_win(m_ptr, req, w, any);
        hs = any && fpu_gnt && (m_count < DEPTH) && !rst;
        rv = fpu_rvalid;
        if (rst) begin
            m_ptr   <= 0;
            m_count <= 0;
            m_err   <= 1'b0;
            q.delete();
        end else begin
            if (hs) begin
                q.push_back('{w, ops[w][1], opc[w][4:0]});
                m_ptr <= (w + 1) % NREQ;
            end
            m_count <= m_count + ((hs && !(rv && m_count == 0)) ? 1 : 0)
                               - ((rv && m_count != 0) ? 1 : 0);
            if (rv && m_count == 0 && !hs) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        int w;
        bit any;
        bit ereq;
        logic [1:0] eg;
        logic [114:0] epay;
        sb_t e;
        exp_win(m_ptr, req, w, any);
        ereq = any && (m_count < DEPTH) && !rst;
        eg   = (ereq && fpu_gnt) ? (2'b01 << w) : 2'b00;
        n_checks++;
        if (gnt_o !== eg) begin
            n_errors++;
            $display("FAIL mon_gnt t=%0t got %b want %b", $time, gnt_o, eg);
        end
        n_checks++;
        if (fpu_req_o !== ereq) begin
            n_errors++;
            $display("FAIL mon_fpu_req t=%0t got %b want %b", $time, fpu_req_o, ereq);
        end
        if (!rst) begin
            epay = any ? {ops[w], opc[w], flg[w]} : '0;
            n_checks++;
            if ({fpu_operands_o, fpu_op_o, fpu_flags_o} !== epay) begin
                n_errors++;
                $display("FAIL mon_payload t=%0t got %h want %h", $time,
                         {fpu_operands_o, fpu_op_o, fpu_flags_o}, epay);
            end
        end
        n_checks++;
        if (int'(dut.w_count) !== m_count) begin
            n_errors++;
            $display("FAIL mon_count t=%0t got %0d want %0d", $time, dut.w_count, m_count);
        end
        n_checks++;
        if (busy_o !== (m_count != 0)) begin
            n_errors++;
            $display("FAIL mon_busy t=%0t got %b want %b", $time, busy_o, m_count != 0);
        end
        n_checks++;
        if (err_o !== m_err) begin
            n_errors++;
            $display("FAIL mon_err t=%0t got %b want %b", $time, err_o, m_err);
        end
        if (rvalid_o !== 2'b00) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL mon_rsp_unexpected t=%0t got rvalid %b want none", $time, rvalid_o);
            end else begin
                e = q.pop_front();
                if (rvalid_o !== (2'b01 << e.owner) || rdata_o[e.owner] !== e.data ||
                    rflags_o[e.owner] !== e.flags) begin
                    n_errors++;
                    $display("FAIL mon_rsp t=%0t got rvalid %b data %h flags %h want owner %0d data %h flags %h",
                             $time, rvalid_o, rdata_o[e.owner], rflags_o[e.owner],
                             e.owner, e.data, e.flags);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic refresh(input int k);
        ops[k][0] = $urandom;
        ops[k][1] = $urandom;
        ops[k][2] = $urandom;
        opc[k]    = {1'b0, 5'($urandom_range(0, 31))};
        flg[k]    = 11'($urandom_range(0, 2047));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11;
        fpu_gnt = 1'b1;
        refresh(0);
        refresh(1);
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b00 || fpu_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_gnt got gnt %b req %b want 00 0", gnt_o, fpu_req_o);
        end
        n_checks++;
        if (rvalid_o !== '0 || rdata_o !== '0 || rflags_o !== '0) begin
            n_errors++;
            $display("FAIL reset_rsp got %b %h %h want zeros", rvalid_o, rdata_o, rflags_o);
        end
        n_checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status got err %b busy %b want 0 0", err_o, busy_o);
        end
        next_cycle();
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_single();
        lat = 0;
        fpu_gnt = 1'b1;
        do_reset();
        ops[0][0] = 32'h40880000;
        ops[0][1] = 32'h40040000;
        ops[0][2] = 32'h0;
        opc[0]    = 6'b001001;
        flg[0]    = 11'b00_000_000_000;
        req = 2'b01;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b01) begin
            n_errors++;
            $display("FAIL single_gnt got %b want 01", gnt_o);
        end
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        n_checks++;
        if (rvalid_o !== 2'b01 || rdata_o[0] !== 32'h40040000 || rflags_o[0] !== 5'b01001) begin
            n_errors++;
            $display("FAIL single_rsp got %b %h %b want 01 40040000 01001",
                     rvalid_o, rdata_o[0], rflags_o[0]);
        end
        next_cycle();
    endtask

    task automatic test_fairness();
        logic [1:0] gexp [4];
        logic [1:0] g;
        gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
        lat = 0;
        fpu_gnt = 1'b1;
        do_reset();
        refresh(0);
        refresh(1);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g = gnt_o;
            n_checks++;
            if (g !== gexp[i]) begin
                n_errors++;
                $display("FAIL fairness_gnt%0d got %b want %b", i, g, gexp[i]);
            end
            next_cycle();
            for (int k = 0; k < NREQ; k++) if (g[k]) refresh(k);
        end
        req = 2'b00;
        repeat (3) next_cycle();
    endtask

    task automatic test_gnt_low();
        lat = 1;
        fpu_gnt = 1'b1;
        do_reset();
        refresh(0);
        refresh(1);
        req = 2'b01;
        next_cycle();
        refresh(0);
        req = 2'b11;
        fpu_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt_o !== 2'b00 || fpu_req_o !== 1'b1) begin
                n_errors++;
                $display("FAIL gnt_low_cycle%0d got gnt %b req %b want 00 1", i, gnt_o, fpu_req_o);
            end
            next_cycle();
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL gnt_low_busy got %b want 0", busy_o);
        end
        fpu_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b10) begin
            n_errors++;
            $display("FAIL gnt_low_resume got %b want 10", gnt_o);
        end
        next_cycle();
        req = 2'b00;
        repeat (3) next_cycle();
    endtask

    task automatic test_backpressure();
        bit anyg [12];
        logic [1:0] g;
        bit done;
        anyg = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        lat = 5;
        fpu_gnt = 1'b1;
        do_reset();
        refresh(0);
        refresh(1);
        req = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            g = gnt_o;
            n_checks++;
            if ((|g) !== anyg[i] || int'(dut.w_count) > DEPTH) begin
                n_errors++;
                $display("FAIL backpressure_c%0d got grant %b count %0d want grant %b count<=%0d",
                         i, |g, dut.w_count, anyg[i], DEPTH);
            end
            next_cycle();
            for (int k = 0; k < NREQ; k++) if (g[k]) refresh(k);
        end
        req = 2'b00;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            done = !busy_o;
            next_cycle();
        end
        n_checks++;
        if (!done || q.size() != 0) begin
            n_errors++;
            $display("FAIL backpressure_drain got busy %b pending %0d want 0 0", busy_o, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        lat = 3;
        fpu_gnt = 1'b1;
        refresh(0);
        refresh(1);
        req = 2'b11;
        repeat (2) begin
            next_cycle();
            refresh(0);
            refresh(1);
        end
        req = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midflight_pre got busy %b want 1", busy_o);
        end
        next_cycle();
        req = 2'b11;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || rvalid_o !== '0 || rdata_o !== '0 || rflags_o !== '0 ||
            err_o !== 1'b0 || gnt_o !== '0 || fpu_req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midflight_reset got busy %b rv %b rd %h rf %h err %b gnt %b req %b want all 0",
                     busy_o, rvalid_o, rdata_o, rflags_o, err_o, gnt_o, fpu_req_o);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 2'b01) begin
            n_errors++;
            $display("FAIL midflight_ptr got %b want 01", gnt_o);
        end
        next_cycle();
        req = 2'b00;
        repeat (6) next_cycle();
    endtask

    task automatic test_orphan();
        lat = 2;
        fpu_gnt = 1'b1;
        do_reset();
        orphan = 1'b1;
        next_cycle();
        orphan = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err_o !== 1'b1 || rvalid_o !== 2'b00) begin
            n_errors++;
            $display("FAIL orphan_set got err %b rvalid %b want 1 00", err_o, rvalid_o);
        end
        refresh(1);
        req = 2'b10;
        next_cycle();
        req = 2'b00;
        repeat (4) next_cycle();
        n_checks++;
        if (err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL orphan_sticky got %b want 1", err_o);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL orphan_clear got %b want 0", err_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] pend;
        logic [1:0] g;
        bit done;
        lat = 2;
        do_reset();
        pend = '0;
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    refresh(k);
                end
            end
            req = pend;
            fpu_gnt = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = gnt_o;
            n_checks++;
            if ((g & ~req) !== 2'b00) begin
                n_errors++;
                $display("FAIL b2b_gnt_c%0d got %b with req %b", c, g, req);
            end
            next_cycle();
            pend = pend & ~g;
        end
        req = 2'b00;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            done = !busy_o;
            next_cycle();
        end
        next_cycle();
        n_checks++;
        if (!done || q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_drain got busy %b pending %0d want 0 0", busy_o, q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        next_cycle();
        test_reset();
        test_single();
        test_fairness();
        test_gnt_low();
        test_backpressure();
        test_reset_midflight();
        test_orphan();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
